// File: rtl/cascade_mod_counter_pkg.sv
// Shared stopwatch time-base definitions: digit width, default stage moduli,
// chain size limit and the per-stage modulus decode helper.
package cascade_mod_counter_pkg;

    localparam int unsigned DIGIT_W    = 4;
    localparam int unsigned MAX_STAGES = 8;

    localparam logic [31:0] MOD_SEC_MIN = 32'h060A060A;
    localparam logic [31:0] MOD_BCD4    = 32'h0A0A0A0A;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    // An 8-bit field of 0 stands for 256 so WIDTH=8 stages can use the full range.
    function automatic int unsigned modulus_of(input logic [8*MAX_STAGES-1:0] moduli,
                                               input int unsigned             idx);
        logic [7:0] field;
        field = moduli[8*idx +: 8];
        return (field == 8'd0) ? 256 : int'(field);
    endfunction

endpackage

// File: rtl/cascade_mod_counter_mod_n_stage.sv
// One modulo-N digit of the cascade: clear/load/step with up/down wrap and
// a combinational terminal-count flag.
module mod_n_stage
    import cascade_mod_counter_pkg::*;
#(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MODULUS = 10
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_d,
    input  logic             step,
    input  logic             down,
    output logic [WIDTH-1:0] digit,
    output logic             tc
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] r_digit;
    logic [WIDTH-1:0] w_next;
    logic [WIDTH-1:0] w_load;
    dir_e             w_dir;

    assign w_dir = dir_e'(down);

    // Out-of-range digits land on 0 (up) or LAST (down) instead of walking back in.
    always_comb begin
        w_next = r_digit;
        unique case (w_dir)
            DIR_UP:   w_next = (r_digit >= LAST) ? '0 : r_digit + WIDTH'(1);
            DIR_DOWN: w_next = ((r_digit == '0) || (r_digit > LAST)) ? LAST
                                                                     : r_digit - WIDTH'(1);
            default:  w_next = r_digit;
        endcase
    end

    assign w_load = (load_d > LAST) ? LAST : load_d;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_digit <= '0;
        end else if (clear) begin
            r_digit <= '0;
        end else if (load) begin
            r_digit <= w_load;
        end else if (step) begin
            r_digit <= w_next;
        end
    end

    assign digit = r_digit;
    assign tc    = (w_dir == DIR_DOWN) ? (r_digit == '0) : (r_digit == LAST);

endmodule

// File: rtl/cascade_mod_counter.sv
// Cascaded modulo-N digit counter for the stopwatch time base: ripple-free
// enable chain across stages plus chain wrap pulse and sticky overflow.
module cascade_mod_counter
    import cascade_mod_counter_pkg::*;
#(
    parameter int unsigned                  STAGES = 4,
    parameter int unsigned                  WIDTH  = DIGIT_W,
    parameter logic [8*MAX_STAGES-1:0]      MODULI = (8*MAX_STAGES)'(MOD_SEC_MIN)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    inc,
    input  logic                    down,
    input  logic                    load,
    input  logic [STAGES*WIDTH-1:0] load_value,
    output logic [STAGES*WIDTH-1:0] count,
    output logic [STAGES-1:0]       stage_tc,
    output logic                    wrap,
    output logic                    overflow
);

    logic [STAGES-1:0] w_tc;
    logic [STAGES-1:0] w_step;
    logic              w_all;
    logic              w_acc;
    logic              r_wrap;
    logic              r_overflow;

    // Stage i steps when inc is high and every lower stage sits at terminal count.
    always_comb begin
        w_acc  = inc;
        w_step = '0;
        for (int unsigned i = 0; i < STAGES; i++) begin
            w_step[i] = w_acc;
            w_acc     = w_acc & w_tc[i];
        end
        w_all = w_acc;
    end

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
        mod_n_stage #(
            .WIDTH  (WIDTH),
            .MODULUS(modulus_of(MODULI, gi))
        ) u_stage (
            .clock (clock),
            .reset (reset),
            .clear (clear),
            .load  (load),
            .load_d(load_value[WIDTH*gi +: WIDTH]),
            .step  (w_step[gi]),
            .down  (down),
            .digit (count[WIDTH*gi +: WIDTH]),
            .tc    (w_tc[gi])
        );
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wrap     <= 1'b0;
            r_overflow <= 1'b0;
        end else if (clear || load) begin
            r_wrap     <= 1'b0;
            r_overflow <= 1'b0;
        end else if (w_all) begin
            r_wrap     <= 1'b1;
            r_overflow <= 1'b1;
        end else begin
            r_wrap     <= 1'b0;
        end
    end

    assign stage_tc = w_tc;
    assign wrap     = r_wrap;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_cascade_mod_counter.sv
// Directed bench for cascade_mod_counter: default mm:ss chain plus a
// two-digit decimal chain checked against a small integer model.
module tb_cascade_mod_counter;

    logic        clock;
    logic        reset;

    logic        a_clear, a_inc, a_down, a_load;
    logic [15:0] a_load_value, a_count;
    logic [3:0]  a_stage_tc;
    logic        a_wrap, a_overflow;

    logic        b_clear, b_inc, b_down, b_load;
    logic [7:0]  b_load_value, b_count;
    logic [1:0]  b_stage_tc;
    logic        b_wrap, b_overflow;

    int unsigned n_total = 0;
    int unsigned n_bad   = 0;

    cascade_mod_counter u_dut_a (
        .clock     (clock),
        .reset     (reset),
        .clear     (a_clear),
        .inc       (a_inc),
        .down      (a_down),
        .load      (a_load),
        .load_value(a_load_value),
        .count     (a_count),
        .stage_tc  (a_stage_tc),
        .wrap      (a_wrap),
        .overflow  (a_overflow)
    );

    cascade_mod_counter #(
        .STAGES(2),
        .WIDTH (4),
        .MODULI(64'h0A0A)
    ) u_dut_b (
        .clock     (clock),
        .reset     (reset),
        .clear     (b_clear),
        .inc       (b_inc),
        .down      (b_down),
        .load      (b_load),
        .load_value(b_load_value),
        .count     (b_count),
        .stage_tc  (b_stage_tc),
        .wrap      (b_wrap),
        .overflow  (b_overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin : main
        int          v;
        int          e_ovf;
        logic        wr;
        logic [7:0]  e_cnt;
        logic [1:0]  e_tc;

        reset = 1'b0;
        a_clear = 0; a_inc = 0; a_down = 0; a_load = 0; a_load_value = '0;
        b_clear = 0; b_inc = 0; b_down = 0; b_load = 0; b_load_value = '0;
        #3;
        chk("rst_count", 32'(a_count), 32'h0);
        chk("rst_wrap", 32'(a_wrap), 32'h0);
        chk("rst_ovf", 32'(a_overflow), 32'h0);
        tick();
        reset = 1'b1;
        tick();

        // Up count through a full hour of mm:ss
        a_inc = 1;
        for (int k = 1; k <= 3601; k++) begin
            tick();
            if (k == 59)   chk("up_59", 32'(a_count), 32'h0059);
            if (k == 60)   chk("up_60", 32'(a_count), 32'h0100);
            if (k == 600)  chk("up_600", 32'(a_count), 32'h1000);
            if (k == 600)  chk("up_600_wrap", 32'(a_wrap), 32'h0);
            if (k == 3599) begin
                chk("up_3599", 32'(a_count), 32'h5959);
                chk("up_3599_tc", 32'(a_stage_tc), 32'hF);
                chk("up_3599_ovf", 32'(a_overflow), 32'h0);
            end
            if (k == 3600) begin
                chk("up_3600", 32'(a_count), 32'h0000);
                chk("up_3600_wrap", 32'(a_wrap), 32'h1);
                chk("up_3600_ovf", 32'(a_overflow), 32'h1);
            end
            if (k == 3601) begin
                chk("up_3601", 32'(a_count), 32'h0001);
                chk("up_3601_wrap", 32'(a_wrap), 32'h0);
                chk("up_3601_ovf", 32'(a_overflow), 32'h1);
            end
        end

        // Clear, then count down from zero
        a_inc = 0; a_clear = 1;
        tick();
        chk("clr_count", 32'(a_count), 32'h0);
        chk("clr_ovf", 32'(a_overflow), 32'h0);
        a_clear = 0; a_down = 1;
        #1;
        chk("dn_tc_zero", 32'(a_stage_tc), 32'hF);
        a_inc = 1;
        tick();
        chk("dn_wrap_count", 32'(a_count), 32'h5959);
        chk("dn_wrap", 32'(a_wrap), 32'h1);
        chk("dn_ovf", 32'(a_overflow), 32'h1);
        tick();
        chk("dn_next", 32'(a_count), 32'h5958);
        chk("dn_next_wrap", 32'(a_wrap), 32'h0);
        a_inc = 0; a_down = 0;
        #1;
        chk("dir_flip_tc", 32'(a_stage_tc), 32'hE);

        // Clamped load, inc ignored
        a_load = 1; a_load_value = 16'h0F9C; a_inc = 1;
        tick();
        chk("load_clamp", 32'(a_count), 32'h0959);
        chk("load_ovf", 32'(a_overflow), 32'h0);
        chk("load_wrap", 32'(a_wrap), 32'h0);

        // clear beats load beats inc
        a_clear = 1; a_load_value = 16'h1234;
        tick();
        chk("prio_count", 32'(a_count), 32'h0);
        a_clear = 0; a_inc = 0;
        tick();
        chk("load_1234", 32'(a_count), 32'h1234);
        a_load = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("hold_%0d", k), 32'(a_count), 32'h1234);
        end

        // Async reset mid-count with overflow set
        a_load = 1; a_load_value = 16'h5959;
        tick();
        a_load = 0; a_inc = 1;
        tick();
        chk("pre_rst_wrap", 32'(a_wrap), 32'h1);
        tick(); tick(); tick();
        chk("pre_rst_count", 32'(a_count), 32'h0003);
        chk("pre_rst_ovf", 32'(a_overflow), 32'h1);
        #2 reset = 1'b0;
        #1;
        chk("async_count", 32'(a_count), 32'h0);
        chk("async_ovf", 32'(a_overflow), 32'h0);
        chk("async_wrap", 32'(a_wrap), 32'h0);
        #2 reset = 1'b1;
        tick();
        chk("post_rst_count", 32'(a_count), 32'h0001);
        a_inc = 0;

        // Two-digit decimal chain with direction toggling
        b_load = 1; b_load_value = 8'h95;
        tick();
        chk("b_load", 32'(b_count), 32'h95);
        b_load = 0;
        v = 95; e_ovf = 0;
        for (int k = 0; k < 63; k++) begin
            b_down = ((k / 7) % 2) == 1;
            b_inc  = (k % 5) != 4;
            #1;
            e_tc[0] = b_down ? ((v % 10) == 0) : ((v % 10) == 9);
            e_tc[1] = b_down ? ((v / 10) == 0) : ((v / 10) == 9);
            chk($sformatf("b_tc_%0d", k), 32'(b_stage_tc), 32'(e_tc));
            wr = 1'b0;
            if (b_inc) begin
                if (b_down) begin
                    wr = (v == 0);
                    v  = wr ? 99 : v - 1;
                end else begin
                    wr = (v == 99);
                    v  = wr ? 0 : v + 1;
                end
                if (wr) e_ovf = 1;
            end
            e_cnt = {4'(v / 10), 4'(v % 10)};
            tick();
            chk($sformatf("b_count_%0d", k), 32'(b_count), 32'(e_cnt));
            chk($sformatf("b_wrap_%0d", k), 32'(b_wrap), 32'(wr));
            chk($sformatf("b_ovf_%0d", k), 32'(b_overflow), 32'(e_ovf));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
